// File: rtl/motor_pkg.sv
// motor_pkg
//   Shared definitions for the motor sequencer: FSM state encoding,
//   one-hot direction request codes, the H-bridge drive pattern for each
//   direction, and small helpers for validating and decoding a direction.
package motor_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_BRAKE = 2'd2,
    ST_FAULT = 2'd3
  } state_t;

  localparam logic [3:0] DIR_FWD   = 4'b0001;
  localparam logic [3:0] DIR_REV   = 4'b0010;
  localparam logic [3:0] DIR_LEFT  = 4'b0100;
  localparam logic [3:0] DIR_RIGHT = 4'b1000;

  // H-bridge pattern {JA4,JA3,JA2,JA1}
  localparam logic [3:0] JA_FWD   = 4'b1010;
  localparam logic [3:0] JA_REV   = 4'b0101;
  localparam logic [3:0] JA_LEFT  = 4'b0110;
  localparam logic [3:0] JA_RIGHT = 4'b1001;
  localparam logic [3:0] JA_OFF   = 4'b0000;

  localparam logic [3:0] FAULT_CNT_MAX = 4'd15;

  // Exactly one bit set
  function automatic logic dir_valid(input logic [3:0] d);
    return (d != 4'd0) && ((d & (d - 4'd1)) == 4'd0);
  endfunction

  function automatic logic [3:0] dir_to_ja(input logic [3:0] d);
    case (d)
      DIR_FWD:   return JA_FWD;
      DIR_REV:   return JA_REV;
      DIR_LEFT:  return JA_LEFT;
      DIR_RIGHT: return JA_RIGHT;
      default:   return JA_OFF;
    endcase
  endfunction

endpackage

// File: rtl/oc_filter.sv
// oc_filter
//   Two-flop synchronizer for an asynchronous overcurrent comparator,
//   followed by a consecutive-high filter.
//   Ports:
//     clock   - system clock
//     reset   - asynchronous active-low reset
//     i_comp  - raw comparator input (asynchronous, active high)
//     o_level - synchronized comparator level
//     o_event - high while the synchronized level has been high for at
//               least OC_FILTER consecutive cycles
module oc_filter
  import motor_pkg::*;
#(
  parameter int OC_FILTER = 16
) (
  input  logic clock,
  input  logic reset,
  input  logic i_comp,
  output logic o_level,
  output logic o_event
);

  localparam int            CW      = (OC_FILTER > 1) ? $clog2(OC_FILTER) : 1;
  localparam logic [CW-1:0] CNT_TOP = CW'(OC_FILTER - 1);

  logic          r_meta;
  logic          r_sync;
  logic [CW-1:0] r_cnt;

  // r_cnt holds (consecutive high cycles - 1) while r_sync is high, so the
  // event fires in the OC_FILTER-th high cycle without an extra flop of delay.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
      r_cnt  <= '0;
    end else begin
      r_meta <= i_comp;
      r_sync <= r_meta;
      if (!r_sync)
        r_cnt <= '0;
      else if (r_cnt != CNT_TOP)
        r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_level = r_sync;
  assign o_event = r_sync && (r_cnt == CNT_TOP);

endmodule

// File: rtl/motor_sequencer.sv
// motor_sequencer
//   Direction/speed sequencer for a two-motor H-bridge with dead-time
//   braking on direction reversal and filtered overcurrent lockout.
//   Ports:
//     clock, reset         - system clock, asynchronous active-low reset
//     dir_cmd[3:0]         - one-hot direction: fwd, rev, left, right
//     speed_cmd[2:0]       - requested speed 0..7
//     compA, compB         - async overcurrent comparators (active high)
//     enableA, enableB     - PWM enables (registered)
//     ja[3:0]              - H-bridge inputs {JA4,JA3,JA2,JA1} (registered)
//     state[1:0]           - FSM state code
//     fault_count[3:0]     - saturating count of FAULT entries
//   Build option: define MOTOR_SEQ_RAMP_EN to ramp the applied duty up by
//   PWM_PERIOD/8 every RAMP_TICKS cycles; otherwise the target duty takes
//   effect at the next PWM period boundary.
//
//   state | meaning
//   IDLE  | bridge off, waiting for a valid direction with nonzero speed
//   RUN   | driving latched direction, PWM on enables
//   BRAKE | dead time after a direction change, bridge off
//   FAULT | overcurrent lockout, bridge off
module motor_sequencer
  import motor_pkg::*;
#(
  parameter int PWM_PERIOD  = 800,
  parameter int DEAD_CYCLES = 1000,
  parameter int OC_FILTER   = 16,
  parameter int OC_HOLD     = 100000,
  parameter int RAMP_TICKS  = 4000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [3:0] dir_cmd,
  input  logic [2:0] speed_cmd,
  input  logic       compA,
  input  logic       compB,
  output logic       enableA,
  output logic       enableB,
  output logic [3:0] ja,
  output logic [1:0] state,
  output logic [3:0] fault_count
);

  // One width serves every down-counter (brake, fault hold, ramp tick).
  localparam int TMAX0 = (DEAD_CYCLES > OC_HOLD) ? DEAD_CYCLES : OC_HOLD;
  localparam int TMAX  = (TMAX0 > RAMP_TICKS) ? TMAX0 : RAMP_TICKS;
  localparam int TW    = $clog2(TMAX + 1);
  localparam int DW    = $clog2(PWM_PERIOD) + 1;

  localparam logic [TW-1:0] DEAD_LOAD = TW'(DEAD_CYCLES - 1);
  localparam logic [TW-1:0] HOLD_LOAD = TW'(OC_HOLD - 1);
  localparam logic [DW-1:0] STEP      = DW'(PWM_PERIOD / 8);
  localparam logic [DW-1:0] PWM_LAST  = DW'(PWM_PERIOD - 1);

  state_t        r_state, w_state_nxt;
  logic [3:0]    r_dir, w_dir_nxt;
  logic [TW-1:0] r_timer, w_timer_nxt;
  logic [3:0]    r_fault_cnt, w_fault_cnt_nxt;
  logic [DW-1:0] r_pwm_cnt, w_pwm_cnt_nxt;
  logic [DW-1:0] r_duty, w_duty_nxt;
  logic [DW-1:0] w_target;
  logic          r_en;
  logic [3:0]    r_ja;

  logic w_lvl_a, w_lvl_b, w_oc_a, w_oc_b, w_oc, w_cmd_ok;

  oc_filter #(.OC_FILTER(OC_FILTER)) u_oc_a (
    .clock   (clock),
    .reset   (reset),
    .i_comp  (compA),
    .o_level (w_lvl_a),
    .o_event (w_oc_a)
  );

  oc_filter #(.OC_FILTER(OC_FILTER)) u_oc_b (
    .clock   (clock),
    .reset   (reset),
    .i_comp  (compB),
    .o_level (w_lvl_b),
    .o_event (w_oc_b)
  );

  assign w_oc     = w_oc_a || w_oc_b;
  assign w_cmd_ok = dir_valid(dir_cmd) && (speed_cmd != 3'd0);
  assign w_target = {{(DW-3){1'b0}}, speed_cmd} * STEP;

  always_comb begin
    w_state_nxt     = r_state;
    w_dir_nxt       = r_dir;
    w_timer_nxt     = r_timer;
    w_fault_cnt_nxt = r_fault_cnt;
    // In FAULT the hold timer keeps running even while the event persists;
    // exit needs the timer expired and both comparators quiet.
    if (r_state == ST_FAULT) begin
      if (r_timer != '0)
        w_timer_nxt = r_timer - 1'b1;
      else if (!w_lvl_a && !w_lvl_b)
        w_state_nxt = ST_IDLE;
    end else if (w_oc) begin
      w_state_nxt = ST_FAULT;
      w_timer_nxt = HOLD_LOAD;
      if (r_fault_cnt != FAULT_CNT_MAX)
        w_fault_cnt_nxt = r_fault_cnt + 4'd1;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_cmd_ok) begin
            w_state_nxt = ST_RUN;
            w_dir_nxt   = dir_cmd;
          end
        end
        ST_RUN: begin
          if (!w_cmd_ok)
            w_state_nxt = ST_IDLE;
          else if (dir_cmd != r_dir) begin
            w_state_nxt = ST_BRAKE;
            w_timer_nxt = DEAD_LOAD;
          end
        end
        ST_BRAKE: begin
          // Commands are only sampled on the last dead-time cycle.
          if (r_timer != '0)
            w_timer_nxt = r_timer - 1'b1;
          else if (w_cmd_ok) begin
            w_state_nxt = ST_RUN;
            w_dir_nxt   = dir_cmd;
          end else
            w_state_nxt = ST_IDLE;
        end
        default: ;
      endcase
    end
  end

  assign w_pwm_cnt_nxt = (r_pwm_cnt == PWM_LAST) ? '0 : r_pwm_cnt + 1'b1;

`ifdef MOTOR_SEQ_RAMP_EN
  logic [TW-1:0] r_ramp_cnt, w_ramp_cnt_nxt;
  localparam logic [TW-1:0] RAMP_LOAD = TW'(RAMP_TICKS - 1);

  // Ramp only upward; a lower target or leaving RUN applies at once.
  always_comb begin
    w_ramp_cnt_nxt = r_ramp_cnt;
    w_duty_nxt     = r_duty;
    if (w_state_nxt != ST_RUN) begin
      w_duty_nxt     = '0;
      w_ramp_cnt_nxt = RAMP_LOAD;
    end else if (w_target <= r_duty) begin
      w_duty_nxt     = w_target;
      w_ramp_cnt_nxt = RAMP_LOAD;
    end else if (r_ramp_cnt != '0) begin
      w_ramp_cnt_nxt = r_ramp_cnt - 1'b1;
    end else begin
      w_ramp_cnt_nxt = RAMP_LOAD;
      w_duty_nxt     = ((w_target - r_duty) > STEP) ? (r_duty + STEP) : w_target;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset)
      r_ramp_cnt <= RAMP_LOAD;
    else
      r_ramp_cnt <= w_ramp_cnt_nxt;
  end
`else
  assign w_duty_nxt = (r_pwm_cnt == PWM_LAST) ? w_target : r_duty;
`endif

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state     <= ST_IDLE;
      r_dir       <= 4'd0;
      r_timer     <= '0;
      r_fault_cnt <= 4'd0;
      r_pwm_cnt   <= '0;
      r_duty      <= '0;
      r_en        <= 1'b0;
      r_ja        <= JA_OFF;
    end else begin
      r_state     <= w_state_nxt;
      r_dir       <= w_dir_nxt;
      r_timer     <= w_timer_nxt;
      r_fault_cnt <= w_fault_cnt_nxt;
      r_pwm_cnt   <= w_pwm_cnt_nxt;
      r_duty      <= w_duty_nxt;
      // Outputs are registered from next-cycle values so they line up
      // with the state register.
      r_en        <= (w_state_nxt == ST_RUN) && (w_pwm_cnt_nxt < w_duty_nxt);
      r_ja        <= (w_state_nxt == ST_RUN) ? dir_to_ja(w_dir_nxt) : JA_OFF;
    end
  end

  assign state       = r_state;
  assign ja          = r_ja;
  assign enableA     = r_en;
  assign enableB     = r_en;
  assign fault_count = r_fault_cnt;

endmodule
